// File: rtl/video_ula_serializer.sv
// video_ula_serializer: MC6845 pixel back-end producing char_clk and palette-mapped RGB pixels
// Ports:
//   pixel_clk, nRESET        16 MHz clock, asynchronous active-low reset
//   wr_en, A0, data_in       register write (A0=0 control, A0=1 palette {index,value})
//   ram_data, display_en,    framestore byte and CRTC timing inputs, latched once per character
//   cursor
//   char_clk                 character clock to the CRTC (2 MHz fast / 1 MHz slow)
//   red, green, blue         registered pixel colour
// Optional: define VIDULA_FLASH_EN so palette bit 3 together with ctrl[0] inverts the colour.
module video_ula_serializer #(
  parameter logic [3:0] PAL_RESET = 4'h7
) (
  input  logic       pixel_clk,
  input  logic       nRESET,
  input  logic       wr_en,
  input  logic       A0,
  input  logic [7:0] data_in,
  input  logic [7:0] ram_data,
  input  logic       display_en,
  input  logic       cursor,
  output logic       char_clk,
  output logic       red,
  output logic       green,
  output logic       blue
);
  logic [7:0] ctrl;
  logic [3:0] palette [16];
  logic [3:0] ph, ph_next, m, logical, phys;
  logic [7:0] sr;
  logic       de_q, cur_q, load, shift, flash, cursor_active, unused;
  logic [1:0] cur_cnt;
  logic [2:0] col;
  // ph==15 is also terminal in fast mode so a late switch to fast finishes one long period
  always_comb begin
    load          = ph == 4'd15 || (ctrl[4] && ph == 4'd7);
    ph_next       = load ? 4'd0 : ph + 4'd1;
    m             = ctrl[3:2] == 2'b11 ? 4'd0 : ctrl[3:2] == 2'b10 ? 4'd1 : ctrl[3:2] == 2'b01 ? 4'd3 : 4'd7;
    shift         = (ph & m) == m;
    logical       = {sr[7], sr[5], sr[3], sr[1]};
    phys          = palette[logical];
`ifdef VIDULA_FLASH_EN
    flash         = phys[3] & ctrl[0];
`else
    flash         = 1'b0;
`endif
    cursor_active = cur_q & ((cur_cnt == 2'd0 & ctrl[7]) | (cur_cnt == 2'd1 & ctrl[6]) | (cur_cnt[1] & ctrl[5]));
    col           = (de_q ? ~phys[2:0] ^ {3{flash}} : 3'b000) ^ {3{cursor_active}};
  end
  // reserved and build-dependent bits deliberately have no other load
  assign unused = ^{ctrl[1], ctrl[0], phys[3]};
  always_ff @(posedge pixel_clk or negedge nRESET) begin
    if (!nRESET) begin
      ctrl     <= 8'h00;
      for (int i = 0; i < 16; i++) palette[i] <= PAL_RESET;
      ph       <= 4'd0;
      sr       <= 8'hFF;
      de_q     <= 1'b0;
      cur_q    <= 1'b0;
      cur_cnt  <= 2'd0;
      char_clk <= 1'b1;
      {red, green, blue} <= 3'b000;
    end else begin
      if (wr_en && !A0) ctrl <= data_in;
      if (wr_en && A0) palette[data_in[7:4]] <= data_in[3:0];
      ph       <= ph_next;
      // registered from the next phase so char_clk lines up with ph, not one cycle behind
      char_clk <= ctrl[4] ? ph_next < 4'd4 : ph_next < 4'd8;
      if (load) begin
        sr      <= ram_data;
        de_q    <= display_en;
        // cur_q marks a live cursor run; it drops on the load after the fourth character
        cur_q   <= cursor | (cur_q & cur_cnt != 2'd3);
        cur_cnt <= cursor ? 2'd0 : cur_cnt == 2'd3 ? cur_cnt : cur_cnt + 2'd1;
      end else if (shift) begin
        sr <= {sr[6:0], 1'b1};
      end
      {red, green, blue} <= col;
    end
  end
endmodule
